// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: gates a real sample stream into N-point FFT frames,
// passing 2^log_count_averages frames per averaging group and then dropping
// 2^log_throttle - 1 frames. Optional macro FFT_CONFIG_EN adds a one-shot
// FFT core configuration handshake before the first frame is passed.
module fft_frame_scheduler #(
  parameter int AXIS_TDATA_WIDTH_IN  = 16,
  parameter int AXIS_TDATA_WIDTH_OUT = 32,
  parameter int LOG_FFT_LENGTH       = 8
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [31:0]                     GPIO,
  input  logic [AXIS_TDATA_WIDTH_IN-1:0]  S_AXIS_tdata,
  input  logic                            S_AXIS_tvalid,
  output logic                            S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH_OUT-1:0] M_AXIS_tdata,
  output logic                            M_AXIS_tvalid,
  input  logic                            M_AXIS_tready,
  output logic                            M_AXIS_tlast,
  output logic                            M_AXIS_tuser,
  output logic [7:0]                      M_AXIS_config_tdata,
  output logic                            M_AXIS_config_tvalid,
  input  logic                            M_AXIS_config_tready
);

  localparam int HALF = AXIS_TDATA_WIDTH_OUT / 2;

  typedef enum logic [1:0] {IDLE, CONFIG, PASS, DROP} state_t;

  state_t                    state;
  logic                      pass_q;
  logic                      drop_q;
  logic [LOG_FFT_LENGTH-1:0] sample_cnt;
  logic [31:0]               frame_cnt;
  logic [31:0]               drop_cnt;
  logic [4:0]                lca_q;
  logic [4:0]                lt_q;

  logic                      enable;
  logic                      beat;
  logic                      frame_end;
  logic                      group_end;
  logic [31:0]               throttle;
  logic [HALF-1:0]           sample_ext;
  logic                      unused_inputs;

  assign enable     = GPIO[0];
  assign throttle   = (32'd1 << lt_q) - 32'd1;
  assign frame_end  = &sample_cnt;
  assign group_end  = (frame_cnt == ((32'd1 << lca_q) - 32'd1));
  assign sample_ext = HALF'($signed(S_AXIS_tdata));

  // Stream side: combinational pass-through in PASS, sink in IDLE/DROP, stall in CONFIG
  assign S_AXIS_tready = pass_q ? M_AXIS_tready : (state != CONFIG);
  assign beat          = S_AXIS_tvalid && S_AXIS_tready && (pass_q || drop_q);
  assign M_AXIS_tvalid = pass_q && S_AXIS_tvalid;
  assign M_AXIS_tlast  = pass_q && frame_end;
  assign M_AXIS_tuser  = pass_q && (frame_cnt == 32'd0);
  assign M_AXIS_tdata  = pass_q ? {{(AXIS_TDATA_WIDTH_OUT-HALF){1'b0}}, sample_ext} : '0;

`ifdef FFT_CONFIG_EN
  logic cfg_valid_q;
  assign M_AXIS_config_tvalid = cfg_valid_q;
  assign M_AXIS_config_tdata  = cfg_valid_q ? 8'h01 : 8'h00;
  assign unused_inputs        = ^GPIO[31:11];
`else
  assign M_AXIS_config_tvalid = 1'b0;
  assign M_AXIS_config_tdata  = '0;
  assign unused_inputs        = ^{GPIO[31:11], M_AXIS_config_tready};
`endif

  // Frame scheduler FSM with sample, frame and drop counters
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      pass_q     <= 1'b0;
      drop_q     <= 1'b0;
      sample_cnt <= '0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      lca_q      <= '0;
      lt_q       <= '0;
`ifdef FFT_CONFIG_EN
      cfg_valid_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            lca_q      <= GPIO[5:1];
            lt_q       <= GPIO[10:6];
            sample_cnt <= '0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
`ifdef FFT_CONFIG_EN
            state       <= CONFIG;
            cfg_valid_q <= 1'b1;
`else
            state  <= PASS;
            pass_q <= 1'b1;
`endif
          end
        end
        CONFIG: begin
`ifdef FFT_CONFIG_EN
          if (!enable) begin
            state       <= IDLE;
            cfg_valid_q <= 1'b0;
          end else if (M_AXIS_config_tready) begin
            state       <= PASS;
            cfg_valid_q <= 1'b0;
            pass_q      <= 1'b1;
          end
`else
          state <= IDLE;
`endif
        end
        PASS: begin
          if (beat) begin
            sample_cnt <= sample_cnt + LOG_FFT_LENGTH'(1);
            // enable is only honoured on the tlast beat so the FFT never sees a partial frame
            if (frame_end) begin
              if (!enable) begin
                state  <= IDLE;
                pass_q <= 1'b0;
              end else if (group_end) begin
                frame_cnt <= '0;
                if (throttle != 32'd0) begin
                  state    <= DROP;
                  pass_q   <= 1'b0;
                  drop_q   <= 1'b1;
                  drop_cnt <= '0;
                end
              end else begin
                frame_cnt <= frame_cnt + 32'd1;
              end
            end
          end
        end
        DROP: begin
          if (!enable) begin
            state  <= IDLE;
            drop_q <= 1'b0;
          end else if (beat) begin
            sample_cnt <= sample_cnt + LOG_FFT_LENGTH'(1);
            if (frame_end) begin
              if (drop_cnt == throttle - 32'd1) begin
                drop_cnt <= '0;
                state    <= PASS;
                drop_q   <= 1'b0;
                pass_q   <= 1'b1;
              end else begin
                drop_cnt <= drop_cnt + 32'd1;
              end
            end
          end
        end
        default: begin
          state  <= IDLE;
          pass_q <= 1'b0;
          drop_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler (default parameters).
// A frame-position model predicts pass/drop, tlast and tuser per accepted
// sample; passed samples are queued and compared against the M_AXIS beats.
module tb_fft_frame_scheduler;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] GPIO;
  logic [15:0] S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic        S_AXIS_tready;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;
  logic        M_AXIS_tlast;
  logic        M_AXIS_tuser;
  logic [7:0]  M_AXIS_config_tdata;
  logic        M_AXIS_config_tvalid;
  logic        M_AXIS_config_tready;

  fft_frame_scheduler #(
    .AXIS_TDATA_WIDTH_IN (16),
    .AXIS_TDATA_WIDTH_OUT(32),
    .LOG_FFT_LENGTH      (8)
  ) dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .GPIO                (GPIO),
    .S_AXIS_tdata        (S_AXIS_tdata),
    .S_AXIS_tvalid       (S_AXIS_tvalid),
    .S_AXIS_tready       (S_AXIS_tready),
    .M_AXIS_tdata        (M_AXIS_tdata),
    .M_AXIS_tvalid       (M_AXIS_tvalid),
    .M_AXIS_tready       (M_AXIS_tready),
    .M_AXIS_tlast        (M_AXIS_tlast),
    .M_AXIS_tuser        (M_AXIS_tuser),
    .M_AXIS_config_tdata (M_AXIS_config_tdata),
    .M_AXIS_config_tvalid(M_AXIS_config_tvalid),
    .M_AXIS_config_tready(M_AXIS_config_tready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        u;
  } exp_t;

  exp_t            q[$];
  int              n_checks = 0;
  int              n_err    = 0;
  logic            mon_on   = 1'b0;
  logic            acc_q    = 1'b0;
  logic            toggle   = 1'b0;
  longint unsigned k        = 0;
  longint unsigned stop_k   = 64'hFFFF_FFFF_FFFF;
  longint unsigned a_frames = 1;
  longint unsigned t_frames = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model of frame position and scoreboard push/pop, sampled mid-cycle
  always @(negedge aclk) begin
    longint unsigned pos;
    logic            exp_pass;
    exp_t            e;
    if (mon_on) begin
      pos      = (k / 256) % (a_frames + t_frames);
      exp_pass = (k < stop_k) && (pos < a_frames);
      check("s_tready", S_AXIS_tready, exp_pass ? M_AXIS_tready : 1'b1);
      check("m_tvalid", M_AXIS_tvalid, exp_pass && S_AXIS_tvalid);
      check("cfg_tvalid_run", M_AXIS_config_tvalid, 1'b0);
      acc_q = S_AXIS_tvalid && S_AXIS_tready;
      if (acc_q) begin
        if (exp_pass) begin
          e.d = {16'h0000, S_AXIS_tdata};
          e.l = ((k % 256) == 255);
          e.u = (pos == 0);
          q.push_back(e);
        end
        k++;
      end
      if (M_AXIS_tvalid && M_AXIS_tready) begin
        check("queue_nonempty", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("tdata", M_AXIS_tdata, e.d);
          check("tlast", M_AXIS_tlast, e.l);
          check("tuser", M_AXIS_tuser, e.u);
        end
      end
    end else begin
      acc_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    if (acc_q) S_AXIS_tdata = 16'($urandom);
    if (toggle) M_AXIS_tready = ~M_AXIS_tready;
  endtask

  task automatic begin_model(input logic [31:0] g);
    k        = 0;
    stop_k   = 64'hFFFF_FFFF_FFFF;
    a_frames = 64'd1 << ((g >> 1) & 32'd31);
    t_frames = (64'd1 << ((g >> 6) & 32'd31)) - 64'd1;
    q.delete();
    mon_on   = 1'b1;
  endtask

  task automatic start(input logic [31:0] g);
    GPIO    = g;
    aresetn = 1'b1;
    tick();
`ifdef FFT_CONFIG_EN
    tick();
`endif
    begin_model(g);
  endtask

  task automatic run_to(input longint unsigned target);
    int cyc;
    cyc = 0;
    while (k < target && cyc < int'(4 * target + 200)) begin
      tick();
      cyc++;
    end
    check("beats_reached", k, target);
  endtask

  task automatic reset_check();
    check("queue_drained", q.size(), 0);
    mon_on        = 1'b0;
    toggle        = 1'b0;
    M_AXIS_tready = 1'b1;
    aresetn       = 1'b0;
    tick();
    tick();
    check("rst_m_tvalid", M_AXIS_tvalid, 1'b0);
    check("rst_tlast", M_AXIS_tlast, 1'b0);
    check("rst_tuser", M_AXIS_tuser, 1'b0);
    check("rst_tdata", M_AXIS_tdata, 32'h0);
    check("rst_cfg_tvalid", M_AXIS_config_tvalid, 1'b0);
    check("rst_cfg_tdata", M_AXIS_config_tdata, 8'h00);
    check("rst_s_tready", S_AXIS_tready, 1'b1);
  endtask

  initial begin
    aresetn              = 1'b0;
    GPIO                 = 32'h0;
    S_AXIS_tdata         = 16'h8001;
    S_AXIS_tvalid        = 1'b1;
    M_AXIS_tready        = 1'b1;
    M_AXIS_config_tready = 1'b1;
    tick();
    reset_check();

    // 4 passed frames, 3 dropped frames, two full periods
    start(32'h85);
    run_to(3584);
    reset_check();

    // every frame passed, each its own group
    start(32'h01);
    run_to(768);
    reset_check();

    // enable cleared after 100 beats: frame completes, then idle
    start(32'h01);
    run_to(100);
    GPIO   = 32'h0;
    stop_k = 256;
    run_to(261);
    reset_check();

`ifdef FFT_CONFIG_EN
    // config handshake stalled for 10 cycles
    M_AXIS_config_tready = 1'b0;
    GPIO                 = 32'h01;
    aresetn              = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("cfg_tvalid_hold", M_AXIS_config_tvalid, 1'b1);
      check("cfg_tdata_hold", M_AXIS_config_tdata, 8'h01);
      check("stall_m_tvalid", M_AXIS_tvalid, 1'b0);
      check("stall_s_tready", S_AXIS_tready, 1'b0);
      tick();
    end
    M_AXIS_config_tready = 1'b1;
    tick();
    begin_model(32'h01);
    run_to(300);
    reset_check();
`endif

    // backpressure toggled every cycle
    start(32'h85);
    toggle = 1'b1;
    run_to(3584);
    reset_check();

    // reset mid-frame, then restart from frame 0 beat 0
    start(32'h85);
    run_to(50);
    reset_check();
    start(32'h85);
    run_to(1536);
    reset_check();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_frame_scheduler.md
FFT_FRAME_SCHEDULER -- requirements
Module: fft_frame_scheduler

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH_IN, default 16: width of the real filter-sample input.
REQ-002 SHALL have parameter AXIS_TDATA_WIDTH_OUT, default 32: width of the complex FFT-input word (imag upper half, real lower half).
REQ-003 SHALL have parameter LOG_FFT_LENGTH, default 8: frame length N = 2^LOG_FFT_LENGTH samples.
REQ-004 SHALL have the following ports. The clock is aclk. Reset is aresetn, which is synchronous and active-low.
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- GPIO  in  32  config: bit 0 enable, bits 5-1 log_count_averages, bits 10-6 log_throttle; other bits ignored.
- S_AXIS_tdata  in  AXIS_TDATA_WIDTH_IN  signed filter sample.
- S_AXIS_tvalid  in  1  sample valid.
- S_AXIS_tready  out  1  sample accepted.
- M_AXIS_tdata  out  AXIS_TDATA_WIDTH_OUT  {imag=0, real=sign-extended sample}.
- M_AXIS_tvalid  out  1  FFT input valid.
- M_AXIS_tready  in  1  FFT ready.
- M_AXIS_tlast  out  1  last sample of frame.
- M_AXIS_tuser  out  1  frame is the first frame of an averaging group (averager clear).
- M_AXIS_config_tdata  out  8  FFT core config word.
- M_AXIS_config_tvalid  out  1  config valid.
- M_AXIS_config_tready  in  1  config accepted.

Function
REQ-005 SHALL implement the states IDLE, CONFIG, PASS and DROP.
REQ-006 IDLE: S_AXIS_tready=1 (samples discarded) and M_AXIS_tvalid=0; on enable=1 SHALL latch log_count_averages/log_throttle, clear counters, and go to CONFIG.
REQ-007 CONFIG: SHALL hold config_tvalid=1 with tdata=8'h01 (forward transform) until config_tready; on the handshake cycle SHALL go to PASS.
REQ-008 PASS: S_AXIS_tready SHALL equal M_AXIS_tready and M_AXIS_tvalid SHALL equal S_AXIS_tvalid (combinational pass-through, zero latency); tdata real SHALL be the sign-extended sample and imag SHALL be 0.
REQ-009 Sample counter (LOG_FFT_LENGTH bits) SHALL increment on every accepted beat in PASS and DROP; tlast SHALL be 1 when the count equals N-1 and SHALL wrap to 0 after that beat.
REQ-010 tuser SHALL be 1 for all beats of frame index 0 of each group, else 0.
REQ-011 A group SHALL be A = 2^log_count_averages frames in PASS; after the last beat of frame A-1 the block SHALL go to DROP if T = 2^log_throttle - 1 > 0, else back to PASS with frame index 0.
REQ-012 DROP: S_AXIS_tready=1 and M_AXIS_tvalid=0; after T full frames the block SHALL re-enter PASS at a frame boundary.
REQ-013 Frame and drop counters SHALL be 32 bits; log values above 31 cannot occur (5-bit field).
REQ-014 enable=0 in PASS SHALL take effect only after the tlast beat is accepted (no partial frame to the FFT); in DROP or CONFIG it SHALL go to IDLE on the next cycle, and a pending config tvalid SHALL drop.
REQ-015 GPIO changes other than enable SHALL be ignored until the next IDLE->CONFIG transition.
REQ-016 Simultaneous tlast acceptance and enable=0 SHALL go to IDLE, not DROP/PASS.

Reset
REQ-017 aresetn=0 at a rising edge of aclk SHALL force IDLE and zero all counters, latched config, M_AXIS_config_tvalid and M_AXIS_tvalid; it SHALL take priority over all other events, including mid-frame.

Configuration
REQ-018 With FFT_CONFIG_EN defined, the CONFIG state and handshake SHALL be present as specified.
REQ-019 Without FFT_CONFIG_EN, M_AXIS_config_tvalid SHALL be tied to 0 and config_tdata to 0, and IDLE SHALL go directly to PASS.

Verification
REQ-020 The bench SHALL cover the following directed scenarios, with LOG_FFT_LENGTH=8 and continuous valid/ready:
- GPIO=0x85 -> four 256-beat frames passed, tlast on beats 255/511/767/1023, tuser=1 on beats 0-255 only; then 768 beats dropped (tvalid=0); the pattern repeats.
- GPIO=0x01 -> every frame passed, no DROP, tuser=1 on every frame.
- enable cleared at beat 100 of a PASS frame -> 156 more beats are passed, then tvalid=0 and the state is IDLE.
- config_tready held low for 10 cycles -> config_tvalid stays high with tdata=0x01, and no sample passes until the handshake.
- M_AXIS_tready toggled every cycle -> S_AXIS_tready mirrors it, no sample is lost or duplicated, and tlast appears every 256 accepted beats.
- aresetn pulsed low at beat 50 -> all outputs are zero and the next enable restarts from frame 0, beat 0.
